// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller side takes the master modport; the datapath/bench side takes slave.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath (R, LW, SW, BEQ, J).
// Outputs are decoded combinationally from the state register.
module multicycle_control (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t state_reg;
  logic   is_load_reg;
  logic   illegal_reg;

  // Load/store direction is captured in DECODE so a changing opcode later is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      is_load_reg <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH:  if (bus.mem_ready) state_reg <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW:   begin state_reg <= MEMADR; is_load_reg <= 1'b1; end
            OP_SW:   begin state_reg <= MEMADR; is_load_reg <= 1'b0; end
            OP_R:    state_reg <= EXEC;
            OP_BEQ:  state_reg <= BRANCH;
            OP_J:    state_reg <= JUMP;
            default: begin state_reg <= FETCH; illegal_reg <= 1'b1; end
          endcase
        end
        MEMADR: state_reg <= is_load_reg ? MEMRD : MEMWR;
        MEMRD:  if (bus.mem_ready) state_reg <= MEMWB;
        MEMWB:  state_reg <= FETCH;
        MEMWR:  if (bus.mem_ready) state_reg <= FETCH;
        EXEC:   state_reg <= ALUWB;
        ALUWB:  state_reg <= FETCH;
        BRANCH: state_reg <= FETCH;
        JUMP:   state_reg <= FETCH;
        default: state_reg <= FETCH;
      endcase
    end
  end

  logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic       iord, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
    // Reset holds FETCH, but a ready memory must not leak writes/reads while rst_n is low.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.iord          = iord;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.state         = state_reg;
  assign bus.illegal_op    = illegal_reg;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; opcode and state encodings are fixed by this document.
REQ-002 clk  in  1  single system clock, rising-edge active.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 opcode  in  6  instruction[31:26], sampled from the instruction register.
REQ-005 mem_ready  in  1  memory access completes this cycle.
REQ-006 pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
REQ-007 iord, mem_to_reg, reg_dst, alu_src_a  out  1 each  datapath mux selects.
REQ-008 alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 alu_op  out  2  to ALU control: 00=add, 01=sub (branch compare), 10=R-type funct decode.
REQ-010 pc_source  out  2  00=ALU result, 01=ALUOut register, 10=jump target.
REQ-011 state  out  4  current FSM state, for debug.
REQ-012 illegal_op  out  1  sticky flag for an unsupported opcode.

Function
REQ-013 Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010; all others are illegal.
REQ-014 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9; codes 10-15 unreachable.
REQ-015 One state register, updated on rising clk; outputs are decoded combinationally from state (plus mem_ready where stated).
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-017 FETCH: ir_write=1 and pc_write=1 only when mem_ready=1.
REQ-018 FETCH transitions to DECODE when mem_ready=1; otherwise it holds in FETCH.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-020 DECODE next state: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, J->JUMP, illegal->FETCH with illegal_op set to 1 on the same edge.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state is MEMRD for LW, MEMWR for SW.
REQ-022 MEMRD: mem_read=1, iord=1; it holds until mem_ready=1, then goes to MEMWB.
REQ-023 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state is FETCH.
REQ-024 MEMWR: mem_write=1, iord=1; it holds until mem_ready=1, then goes to FETCH. mem_write stays asserted for every cycle of the hold.
REQ-025 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state is ALUWB.
REQ-026 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state is FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next state is FETCH.
REQ-028 JUMP: pc_write=1, pc_source=10; next state is FETCH.
REQ-029 Any output not listed for a state SHALL be 0.
REQ-030 Unreachable state codes SHALL drive all enables to 0 and transition to FETCH on the next edge.
REQ-031 DECODE SHALL decode the opcode as held in DECODE; opcode changes in other states SHALL have no effect.
REQ-032 Instruction latency in cycles, with zero wait states: LW=5, SW=4, R=4, BEQ=3, J=3.
REQ-033 Each extra cycle with mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency.

Reset
REQ-034 When rst_n is low, the block SHALL immediately force state=FETCH and illegal_op=0, independent of clk.
REQ-035 While rst_n is low, pc_write, ir_write, reg_write, mem_write and pc_write_cond SHALL be 0, even when mem_ready=1.
REQ-036 Reset asserted mid-instruction SHALL abort the instruction; after rst_n is released, the first rising edge evaluates FETCH.
REQ-037 illegal_op SHALL clear only on reset.

Verification
REQ-038 LW, mem_ready held at 1 -> state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in the 5th cycle.
REQ-039 SW with mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles with mem_write=1 throughout; then state 0; reg_write never 1.
REQ-040 R-type, then BEQ, then J, mem_ready=1 -> alu_op 10 in EXEC, 01 in BRANCH with pc_write_cond=1, pc_source=10 with pc_write=1 in JUMP; total 10 cycles.
REQ-041 FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 on both cycles, state remains 0; ir_write=1 on the 3rd cycle.
REQ-042 Opcode 111111 in DECODE -> illegal_op=1 and next state 0; the flag stays 1 through a following LW and clears on an rst_n pulse.
REQ-043 rst_n pulsed low while in MEMRD, asynchronous to clk -> state=0 and all enables 0 immediately, without waiting for a clock edge.
